// File: rtl/jts16_busdec_pkg.sv
// jts16_busdec_pkg: shared FSM states and constants for the System 16 bus decoder
package jts16_busdec_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_DEC, ST_WAIT, ST_ACK, ST_ERR} state_t;
  localparam logic [15:0] BUS_OPEN = 16'hFFFF;
  localparam int WDW = 8;
endpackage

// File: rtl/jts16_busdec_match.sv
// jts16_busdec_match: combinational address-window priority matcher, lowest index wins
module jts16_busdec_match #(
  parameter int NREG = 8,
  parameter int AW   = 23,
  parameter int IW   = NREG > 1 ? $clog2(NREG) : 1
) (
  input  logic [AW-1:0]      addr,
  input  logic [NREG*AW-1:0] win_mask,
  input  logic [NREG*AW-1:0] win_val,
  output logic               hit,
  output logic [IW-1:0]      idx
);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NREG - 1; i >= 0; i--)
      if (((addr ^ win_val[i*AW+:AW]) & win_mask[i*AW+:AW]) == '0) begin
        hit = 1'b1;
        idx = IW'(i);
      end
  end
endmodule

// File: rtl/jts16_busdec.sv
// jts16_busdec: 68000 bus decoder with per-window ready handshake and DTACK/BERR control
// Define JTS16_BUSDEC_BERR_EN to enable bus errors on unmapped accesses and the wait watchdog.
module jts16_busdec
  import jts16_busdec_pkg::*;
#(
  parameter int NREG = 8,
  parameter int AW   = 23,
  parameter int TOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      addr,
  input  logic               ASn,
  input  logic               UDSn,
  input  logic               LDSn,
  input  logic               RnW,
  input  logic               BGACKn,
  input  logic [NREG*AW-1:0] win_mask,
  input  logic [NREG*AW-1:0] win_val,
  input  logic [NREG-1:0]    win_wait,
  input  logic [NREG-1:0]    reg_ok,
  input  logic [NREG*16-1:0] reg_dout,
  output logic [NREG-1:0]    cs,
  output logic [15:0]        cpu_din,
  output logic               DTACKn,
  output logic               BERRn,
  output logic               busy
);
  localparam int IW = NREG > 1 ? $clog2(NREG) : 1;
  state_t st, nx;
  logic bus_n, m_hit, hit, cap, wd_exp;
  logic [IW-1:0] m_idx, idx;
  logic [15:0] sel_dout;
  assign bus_n    = ASn | (UDSn & LDSn);
  assign sel_dout = reg_dout[idx*16+:16];
  assign busy     = st != ST_IDLE;
  jts16_busdec_match #(.NREG(NREG), .AW(AW), .IW(IW)) u_match (
    .addr(addr), .win_mask(win_mask), .win_val(win_val), .hit(m_hit), .idx(m_idx)
  );
`ifdef JTS16_BUSDEC_BERR_EN
  localparam bit BERR_EN = 1'b1;
  logic [WDW-1:0] wd;
  assign wd_exp = wd == WDW'(TOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wd    <= '0;
      BERRn <= 1'b1;
    end else begin
      wd    <= st == ST_DEC ? '0 : st == ST_WAIT ? wd + 1'b1 : wd;
      BERRn <= st != ST_ERR;
    end
`else
  localparam bit BERR_EN = 1'b0;
  assign wd_exp = 1'b0;
  assign BERRn  = 1'b1;
`endif
  always_comb begin
    nx  = st;
    cap = 1'b0;
    case (st)
      ST_IDLE: nx = !bus_n && BGACKn ? ST_DEC : ST_IDLE;
      ST_DEC:
        if (ASn) nx = ST_IDLE;
        else if (!hit) begin
          nx  = BERR_EN ? ST_ERR : ST_ACK;
          cap = !BERR_EN && RnW;
        end else if (win_wait[idx]) nx = ST_WAIT;
        else begin
          nx  = ST_ACK;
          cap = RnW;
        end
      ST_WAIT:
        if (ASn) nx = ST_IDLE;
        else if (reg_ok[idx]) begin
          nx  = ST_ACK;
          cap = RnW;
        end else if (wd_exp) nx = ST_ERR;
      ST_ACK:  nx = bus_n ? ST_IDLE : ST_ACK;
      ST_ERR:  nx = ASn ? ST_IDLE : ST_ERR;
      default: nx = ST_IDLE;
    endcase
  end
  // cs and DTACKn follow the current state, so both release one cycle after BUSn is seen high
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st      <= ST_IDLE;
      hit     <= 1'b0;
      idx     <= '0;
      cs      <= '0;
      cpu_din <= BUS_OPEN;
      DTACKn  <= 1'b1;
    end else begin
      st <= nx;
      if (st == ST_IDLE) begin
        hit <= m_hit;
        idx <= m_idx;
      end
      cs      <= hit && (st == ST_ACK || ((st == ST_DEC || st == ST_WAIT) && !ASn)) ? NREG'(1) << idx : '0;
      DTACKn  <= st != ST_ACK;
      cpu_din <= cap ? (hit ? sel_dout : BUS_OPEN) : cpu_din;
    end
endmodule

// File: tb/tb_jts16_busdec.sv
// tb_jts16_busdec: directed checks of decode, wait handshake, RMW, unmapped access, watchdog and reset
module tb_jts16_busdec;
  localparam int NREG = 8;
  localparam int AW = 23;
  logic clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] addr = '0;
  logic ASn = 1'b1, UDSn = 1'b1, LDSn = 1'b1, RnW = 1'b1, BGACKn = 1'b1;
  logic [NREG*AW-1:0] win_mask, win_val;
  logic [NREG-1:0] win_wait = '0, reg_ok = '0;
  logic [NREG*16-1:0] reg_dout = '0;
  logic [NREG-1:0] cs;
  logic [15:0] cpu_din;
  logic DTACKn, BERRn, busy;
  int checks = 0, errors = 0;

  jts16_busdec #(.NREG(NREG), .AW(AW), .TOUT(16)) dut (
    .clk(clk), .rst(rst), .addr(addr), .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn), .RnW(RnW),
    .BGACKn(BGACKn), .win_mask(win_mask), .win_val(win_val), .win_wait(win_wait),
    .reg_ok(reg_ok), .reg_dout(reg_dout), .cs(cs), .cpu_din(cpu_din), .DTACKn(DTACKn),
    .BERRn(BERRn), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, o, e);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input logic [AW-1:0] a, input logic rw);
    addr = a;
    RnW  = rw;
    ASn  = 1'b0;
    UDSn = 1'b0;
    LDSn = 1'b0;
  endtask

  task automatic stop();
    ASn  = 1'b1;
    UDSn = 1'b1;
    LDSn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin
      win_mask[i*AW+:AW] = 23'h7FFFFF;
      win_val[i*AW+:AW]  = 23'h7FFFFF;
    end
    win_mask[0*AW+:AW] = 23'h7F0000; win_val[0*AW+:AW] = 23'h000000;
    win_mask[1*AW+:AW] = 23'h7F0000; win_val[1*AW+:AW] = 23'h100000;
    win_mask[2*AW+:AW] = 23'h7F8000; win_val[2*AW+:AW] = 23'h100000;
    win_mask[3*AW+:AW] = 23'h7F0000; win_val[3*AW+:AW] = 23'h200000;
    win_wait[3] = 1'b1;
    reg_dout[0*16+:16] = 16'h1234;
    reg_dout[1*16+:16] = 16'h1111;
    reg_dout[2*16+:16] = 16'h2222;
    reg_dout[3*16+:16] = 16'hBEEF;
    cyc(2);
    chk("rst_cs", 32'(cs), 0);
    chk("rst_din", 32'(cpu_din), 'hFFFF);
    chk("rst_dtack", 32'(DTACKn), 1);
    chk("rst_berr", 32'(BERRn), 1);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    cyc(1);
    // region 0, no wait
    start(23'h000010, 1'b1);
    cyc(1);
    chk("r0_e0_cs", 32'(cs), 0);
    chk("r0_e0_busy", 32'(busy), 1);
    cyc(1);
    chk("r0_e1_cs", 32'(cs), 'h01);
    chk("r0_e1_dtack", 32'(DTACKn), 1);
    cyc(1);
    chk("r0_e2_dtack", 32'(DTACKn), 0);
    chk("r0_e2_din", 32'(cpu_din), 'h1234);
    stop();
    cyc(1);
    chk("r0_rel_hold", 32'(DTACKn), 0);
    cyc(1);
    chk("r0_rel_dtack", 32'(DTACKn), 1);
    chk("r0_rel_cs", 32'(cs), 0);
    chk("r0_rel_busy", 32'(busy), 0);
    // region 3, ready 5 cycles after cs
    start(23'h200004, 1'b1);
    cyc(2);
    chk("r3_cs", 32'(cs), 'h08);
    cyc(4);
    chk("r3_wait_dtack", 32'(DTACKn), 1);
    reg_ok[3] = 1'b1;
    cyc(1);
    chk("r3_ok_dtack", 32'(DTACKn), 1);
    cyc(1);
    chk("r3_ack_dtack", 32'(DTACKn), 0);
    chk("r3_ack_din", 32'(cpu_din), 'hBEEF);
    reg_ok[3] = 1'b0;
    stop();
    cyc(2);
    chk("r3_rel_cs", 32'(cs), 0);
    // read-modify-write on region 3
    reg_ok[3] = 1'b1;
    start(23'h200008, 1'b1);
    cyc(3);
    chk("rmw_rd_cs", 32'(cs), 'h08);
    cyc(1);
    chk("rmw_rd_dtack", 32'(DTACKn), 0);
    chk("rmw_rd_din", 32'(cpu_din), 'hBEEF);
    UDSn = 1'b1;
    LDSn = 1'b1;
    cyc(2);
    chk("rmw_gap_cs", 32'(cs), 0);
    chk("rmw_gap_dtack", 32'(DTACKn), 1);
    reg_dout[3*16+:16] = 16'h5555;
    RnW  = 1'b0;
    UDSn = 1'b0;
    LDSn = 1'b0;
    cyc(2);
    chk("rmw_wr_cs", 32'(cs), 'h08);
    cyc(2);
    chk("rmw_wr_dtack", 32'(DTACKn), 0);
    chk("rmw_wr_din", 32'(cpu_din), 'hBEEF);
    stop();
    RnW = 1'b1;
    reg_ok[3] = 1'b0;
    reg_dout[3*16+:16] = 16'hBEEF;
    cyc(2);
    // unmapped address
    start(23'h300000, 1'b1);
    cyc(2);
    chk("um_cs", 32'(cs), 0);
    cyc(1);
`ifdef JTS16_BUSDEC_BERR_EN
    chk("um_berr", 32'(BERRn), 0);
    chk("um_dtack", 32'(DTACKn), 1);
    chk("um_din", 32'(cpu_din), 'hBEEF);
`else
    chk("um_dtack", 32'(DTACKn), 0);
    chk("um_din", 32'(cpu_din), 'hFFFF);
    chk("um_berr", 32'(BERRn), 1);
`endif
    stop();
    cyc(2);
    chk("um_rel_berr", 32'(BERRn), 1);
    chk("um_rel_dtack", 32'(DTACKn), 1);
    // wait region never ready
    start(23'h200000, 1'b1);
    cyc(2);
`ifdef JTS16_BUSDEC_BERR_EN
    cyc(16);
    chk("wd_e17_berr", 32'(BERRn), 1);
    chk("wd_e17_cs", 32'(cs), 'h08);
    cyc(1);
    chk("wd_e18_berr", 32'(BERRn), 0);
    chk("wd_e18_cs", 32'(cs), 0);
    stop();
    cyc(1);
    chk("wd_hold_berr", 32'(BERRn), 0);
    cyc(1);
    chk("wd_rel_berr", 32'(BERRn), 1);
    chk("wd_rel_busy", 32'(busy), 0);
`else
    cyc(30);
    chk("nowd_dtack", 32'(DTACKn), 1);
    chk("nowd_busy", 32'(busy), 1);
    chk("nowd_cs", 32'(cs), 'h08);
    stop();
    cyc(1);
    chk("abort_cs", 32'(cs), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_dtack", 32'(DTACKn), 1);
    chk("abort_berr", 32'(BERRn), 1);
`endif
    cyc(1);
    // overlapping regions 1 and 2
    start(23'h100000, 1'b1);
    cyc(2);
    chk("ovl_cs", 32'(cs), 'h02);
    cyc(1);
    chk("ovl_din", 32'(cpu_din), 'h1111);
    stop();
    cyc(2);
    // bus granted away: no decode
    BGACKn = 1'b0;
    start(23'h000010, 1'b1);
    cyc(3);
    chk("bgack_busy", 32'(busy), 0);
    chk("bgack_cs", 32'(cs), 0);
    stop();
    BGACKn = 1'b1;
    cyc(1);
    // reset while waiting
    start(23'h200000, 1'b1);
    cyc(4);
    chk("mrst_pre_cs", 32'(cs), 'h08);
    rst = 1'b1;
    #1;
    chk("mrst_cs", 32'(cs), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_dtack", 32'(DTACKn), 1);
    chk("mrst_berr", 32'(BERRn), 1);
    chk("mrst_din", 32'(cpu_din), 'hFFFF);
    stop();
    cyc(1);
    rst = 1'b0;
    cyc(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
